latency_credit_buffer: RTL and testbench

//   Downstream consumer of the fixed-latency delayer pipeline.
//   - Tracks which cycles issued a valid operand into the delayer.
//   - Captures the delayer's result exactly LATENCY cycles after each issue.
//   - Buffers results in a DEPTH-entry FIFO behind a ready/valid output.
//   - The delayer cannot stall, so upstream issue is gated by a credit counter.
//     A result therefore always has a free FIFO slot.
//

---
 rtl/latency_credit_buffer.sv | 77 +++++++
 tb/tb_latency_credit_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/latency_credit_buffer.sv
// Credit-gated capture FIFO behind a fixed-latency, non-stalling delayer.
// Optional pop counter port out_count under `LATENCY_CREDIT_BUFFER_COUNT_EN.
module latency_credit_buffer #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pipe_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef LATENCY_CREDIT_BUFFER_COUNT_EN
  ,
  output logic [31:0]      out_count
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [LATENCY-1:0] vsr;
  logic [AW:0]        credits;
  logic [AW:0]        count;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               issue, push, pop;

  assign in_ready  = (credits != '0);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign issue     = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push      = vsr[LATENCY-1];

  // vsr mirrors the delayer's internal valid pipeline so push lines up with its data
  always_ff @(posedge clock) begin
    if (reset) begin
      vsr     <= '0;
      credits <= (AW+1)'(DEPTH);
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      vsr <= {vsr[LATENCY-2:0], issue};
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; count gates visibility
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr] <= pipe_data;
  end

`ifdef LATENCY_CREDIT_BUFFER_COUNT_EN
  logic [31:0] pop_cnt;
  always_ff @(posedge clock) begin
    if (reset)    pop_cnt <= '0;
    else if (pop) pop_cnt <= pop_cnt + 32'd1;
  end
  assign out_count = pop_cnt;
`endif

endmodule

// File: tb/tb_latency_credit_buffer.sv
// Directed self-checking bench for latency_credit_buffer (WIDTH=32, LATENCY=4, DEPTH=8).
module tb_latency_credit_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pipe_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef LATENCY_CREDIT_BUFFER_COUNT_EN
  logic [31:0] out_count;
`endif

  int checks = 0;
  int errors = 0;

  latency_credit_buffer #(.WIDTH(32), .LATENCY(4), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_data(pipe_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
`ifdef LATENCY_CREDIT_BUFFER_COUNT_EN
    , .out_count(out_count)
`endif
  );

  always #5 clock = ~clock;

  // Each cycle: inputs set and outputs sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pipe_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid  = (c == 0);
      pipe_data = (c == 4) ? 32'hA5A5_0001 : (32'hDEAD_0000 | c);
      checks++;
      if (out_valid !== (c == 5)) begin
        errors++; $display("FAIL single_valid c=%0d got %b want %b", c, out_valid, (c == 5));
      end
      if (c == 5) begin
        checks++;
        if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got %h want a5a50001", out_data); end
      end else begin
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL single_mask c=%0d got %h want 0", c, out_data); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      in_valid  = (c < 16);
      pipe_data = c;
      if (c < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got %b want 1", c, in_ready); end
      end
      checks++;
      if (out_valid !== (c >= 5 && c <= 20)) begin
        errors++; $display("FAIL stream_valid c=%0d got %b want %b", c, out_valid, (c >= 5 && c <= 20));
      end
      if (c >= 5 && c <= 20) begin
        checks++;
        if (out_data !== 32'(c - 1)) begin errors++; $display("FAIL stream_data c=%0d got %0d want %0d", c, out_data, c - 1); end
      end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 21; c++) begin
      pipe_data = 100 + c;
      in_valid  = (c < 12);
      out_ready = (c >= 12);
      if (c < 12) begin
        checks++;
        if (in_ready !== (c < 8)) begin errors++; $display("FAIL fill_in_ready c=%0d got %b want %b", c, in_ready, (c < 8)); end
      end else begin
        checks++;
        if (in_ready !== (c >= 13)) begin errors++; $display("FAIL drain_in_ready c=%0d got %b want %b", c, in_ready, (c >= 13)); end
        checks++;
        if (out_valid !== (c < 20)) begin errors++; $display("FAIL drain_valid c=%0d got %b want %b", c, out_valid, (c < 20)); end
        if (c < 20) begin
          checks++;
          if (out_data !== 32'(104 + c - 12)) begin
            errors++; $display("FAIL drain_data c=%0d got %0d want %0d", c, out_data, 104 + c - 12);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      pipe_data = 32'hBAD0_0000 | c;
      reset     = (c == 2);
      in_valid  = (c <= 2) || (c >= 14);
      out_ready = (c < 14);
      if (c == 3) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
      end
      if (c >= 3 && c < 14) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_emit c=%0d got %b want 0", c, out_valid); end
      end
      // Full credit refill: exactly 8 issues accepted with no pops
      if (c >= 14) begin
        checks++;
        if (in_ready !== (c < 22)) begin errors++; $display("FAIL rstmid_credits c=%0d got %b want %b", c, in_ready, (c < 22)); end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_credit();
    logic [31:0] exp_q[$];
    int pops;
    pops = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(104 + i);
    exp_q.push_back(117);
    do_reset();
    for (int c = 0; c < 40; c++) begin
      pipe_data = 100 + c;
      in_valid  = (c < 14);
      out_ready = (c == 12) || (c >= 14);
      if (c == 12) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL zc_blocked got %b want 0", in_ready); end
      end
      if (c == 13) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL zc_reopen got %b want 1", in_ready); end
      end
      if (c == 14) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL zc_one_issue got %b want 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (pops >= exp_q.size()) begin
          errors++; $display("FAIL zc_extra got %0d want none", out_data);
        end else if (out_data !== exp_q[pops]) begin
          errors++; $display("FAIL zc_order idx=%0d got %0d want %0d", pops, out_data, exp_q[pops]);
        end
        pops++;
      end
      tick();
    end
    checks++;
    if (pops != 9) begin errors++; $display("FAIL zc_total got %0d want 9", pops); end
  endtask

`ifdef LATENCY_CREDIT_BUFFER_COUNT_EN
  task automatic test_count();
    do_reset();
    checks++;
    if (out_count !== 32'd0) begin errors++; $display("FAIL count_reset0 got %0d want 0", out_count); end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid  = (c < 10);
      pipe_data = c;
      tick();
    end
    checks++;
    if (out_count !== 32'd10) begin errors++; $display("FAIL count_ten got %0d want 10", out_count); end
    do_reset();
    checks++;
    if (out_count !== 32'd0) begin errors++; $display("FAIL count_reset got %0d want 0", out_count); end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pipe_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_drain();
    test_reset_mid();
    test_zero_credit();
`ifdef LATENCY_CREDIT_BUFFER_COUNT_EN
    test_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
